// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: hazard/redirect control in, instruction memory port, decode register out.
interface instr_fetch_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   f_to_d_enable;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   imem_rd_en;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr_d;
    logic [PC_WIDTH-1:0]    pc_d;
    logic                   instr_valid_d;

    modport master (
        input  f_to_d_enable, redirect_valid, redirect_pc, imem_rdata,
        output imem_rd_en, imem_addr, instr_d, pc_d, instr_valid_d
    );

    modport slave (
        output f_to_d_enable, redirect_valid, redirect_pc, imem_rdata,
        input  imem_rd_en, imem_addr, instr_d, pc_d, instr_valid_d
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads, and loads the fetch-to-decode
// register, parking an in-flight response in a 1-entry hold buffer while decode is stalled.
module instr_fetch_stage #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master fif
);
    logic [PC_WIDTH-1:0]    pc_p0;
    logic                   issue_p0;
    logic                   vld_p1;
    logic [PC_WIDTH-1:0]    pending_pc_p1;
    logic                   hold_vld;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic [PC_WIDTH-1:0]    hold_pc;
    logic [INSTR_WIDTH-1:0] instr_p2;
    logic [PC_WIDTH-1:0]    pc_p2;
    logic                   vld_p2;
    logic [PC_WIDTH-1:0]    redirect_target;

    assign issue_p0        = rst & fif.f_to_d_enable & ~fif.redirect_valid;
    assign redirect_target = {fif.redirect_pc[PC_WIDTH-1:2], 2'b00};

    assign fif.imem_rd_en    = issue_p0;
    assign fif.imem_addr     = pc_p0;
    assign fif.instr_d       = instr_p2;
    assign fif.pc_d          = pc_p2;
    assign fif.instr_valid_d = vld_p2;

    // p0 -> p1: issue a read; p1 -> p2: route the response (or the held one) into decode
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_p0    <= RESET_PC;
            vld_p1   <= 1'b0;
            hold_vld <= 1'b0;
            instr_p2 <= NOP_INSTR;
            pc_p2    <= '0;
            vld_p2   <= 1'b0;
        end else if (fif.redirect_valid) begin
            // Anything in flight or held belongs to the wrong path
            pc_p0    <= redirect_target;
            vld_p1   <= 1'b0;
            hold_vld <= 1'b0;
            instr_p2 <= NOP_INSTR;
            vld_p2   <= 1'b0;
        end else if (!fif.f_to_d_enable) begin
            vld_p1 <= 1'b0;
            if (vld_p1) begin
                hold_vld   <= 1'b1;
                hold_instr <= fif.imem_rdata;
                hold_pc    <= pending_pc_p1;
            end
        end else begin
            vld_p1        <= 1'b1;
            pending_pc_p1 <= pc_p0;
            pc_p0         <= pc_p0 + PC_WIDTH'(4);
            if (hold_vld) begin
                hold_vld <= 1'b0;
                instr_p2 <= hold_instr;
                pc_p2    <= hold_pc;
                vld_p2   <= 1'b1;
            end else if (vld_p1) begin
                instr_p2 <= fif.imem_rdata;
                pc_p2    <= pending_pc_p1;
                vld_p2   <= 1'b1;
            end else begin
                instr_p2 <= NOP_INSTR;
                vld_p2   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: a queue-based fetch model predicts each cycle's bus and
// decode values, a monitor process compares them against the DUT.
module tb_instr_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit          rd_en;
        bit          chk_addr;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        bit          vld;
        bit          chk_pc;
        bit          chk_dec;
    } item_t;

    logic clk;
    logic rst;
    instr_fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) ifc ();

    instr_fetch_stage #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fif(ifc.master)
    );

    item_t       exp_q[$];
    logic [31:0] inflight_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    bit          m_vld;
    bit          m_known;
    int          n_cmp;
    int          n_bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: data for a read strobed in cycle n appears in cycle n+1, junk otherwise
    initial begin
        logic        re;
        logic [31:0] a;
        ifc.imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            re = ifc.imem_rd_en;
            a  = ifc.imem_addr;
            #1 ifc.imem_rdata = re ? mem_word(a) : $urandom;
        end
    end

    // Model: addresses fetched in program order travel through a FIFO; each decode-advancing cycle
    // delivers the oldest fetch issued in an earlier cycle, or a bubble if there is none.
    task automatic cyc(input bit r, input bit en, input bit rv, input logic [31:0] rpc);
        item_t it;
        logic [31:0] a;
        @(negedge clk);
        rst                = r;
        ifc.f_to_d_enable  = en;
        ifc.redirect_valid = rv;
        ifc.redirect_pc    = rpc;
        it.rd_en    = r && en && !rv;
        it.chk_addr = m_known;
        it.addr     = m_pc;
        it.chk_pc   = 1'b0;
        if (!r) begin
            m_pc = 32'h0;
            inflight_q.delete();
            m_instr = NOP; m_pcd = 32'h0; m_vld = 1'b0;
            m_known = 1'b1;
            it.chk_pc = 1'b1;
        end else if (rv) begin
            m_pc = rpc & ~32'h3;
            inflight_q.delete();
            m_instr = NOP; m_vld = 1'b0;
        end else if (en) begin
            if (inflight_q.size() > 0) begin
                a = inflight_q.pop_front();
                m_instr = mem_word(a); m_pcd = a; m_vld = 1'b1;
            end else begin
                m_instr = NOP; m_vld = 1'b0;
            end
            inflight_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        it.instr   = m_instr;
        it.pc      = m_pcd;
        it.vld     = m_vld;
        it.chk_pc  = it.chk_pc || m_vld;
        it.chk_dec = m_known;
        exp_q.push_back(it);
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) continue;
            it = exp_q[0];
            check("imem_rd_en", {31'b0, ifc.imem_rd_en}, {31'b0, it.rd_en});
            if (it.chk_addr) check("imem_addr", ifc.imem_addr, it.addr);
            @(posedge clk);
            #2;
            if (it.chk_dec) begin
                check("instr_d", ifc.instr_d, it.instr);
                check("instr_valid_d", {31'b0, ifc.instr_valid_d}, {31'b0, it.vld});
                if (it.chk_pc) check("pc_d", ifc.pc_d, it.pc);
            end
            void'(exp_q.pop_front());
        end
    end

    initial begin
        int budget;
        n_cmp = 0; n_bad = 0; m_known = 1'b0;
        m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_vld = 1'b0;
        rst = 1'b0;
        ifc.f_to_d_enable  = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;

        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        // stall with a read in flight fills the hold buffer, then redirect while still stalled
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0101);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0);

        repeat (600)
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) == 0, $urandom);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d items left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
